// File: rtl/timer_device_if.sv
// rtl/timer_device_if.sv - I/O bus address/strobe bundle shared by the CPU and memory-mapped devices
interface timer_device_if;
  logic [31:0] ABUS;
  logic        we;

  modport master (output ABUS, output we);
  modport slave  (input  ABUS, input  we);
endinterface

// File: rtl/timer_device.sv
// rtl/timer_device.sv - memory-mapped prescaled tick counter with limit wrap, Ready/Overrun status and TIRQ
module timer_device #(
  parameter int unsigned TICK_DIV  = 50000,
  parameter logic [31:0] ADDR_TCNT = 32'hF0000020,
  parameter logic [31:0] ADDR_TLIM = 32'hF0000024,
  parameter logic [31:0] ADDR_TCTL = 32'hF0000120
) (
  input  logic          clk,
  input  logic          rst,
  timer_device_if.slave bus,
  inout  wire  [31:0]   DBUS,
  input  logic          IE,
  output logic          TIRQ
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PS_LAST = PW'(TICK_DIV - 1);
  localparam logic [PW-1:0] PS_ONE  = PW'(1);

  logic [PW-1:0] prescaler;
  logic [31:0]   tCnt;
  logic [31:0]   tLim;
  logic          ready;
  logic          overrun;
  logic          intEn;

  logic          hitCnt, hitLim, hitCtl;
  logic          wrCnt, wrLim, wrCtl;
  logic          tick, wrap;
  logic          rdEn;
  logic [31:0]   ctlView;
  logic [31:0]   rdData;

  assign hitCnt = (bus.ABUS == ADDR_TCNT);
  assign hitLim = (bus.ABUS == ADDR_TLIM);
  assign hitCtl = (bus.ABUS == ADDR_TCTL);

  assign wrCnt = bus.we & hitCnt;
  assign wrLim = bus.we & hitLim;
  assign wrCtl = bus.we & hitCtl;

  assign tick = (prescaler == PS_LAST);
  // A software write to TCNT or TLIM replaces the count, so that edge is not a wrap.
  assign wrap = tick && (tLim != 32'd0) && (tCnt == tLim - 32'd1) && !wrCnt && !wrLim;

  assign ctlView = {23'b0, intEn, 5'b0, overrun, 1'b0, ready};

  always_comb begin
    rdData = 32'd0;
    if (hitCnt)      rdData = tCnt;
    else if (hitLim) rdData = tLim;
    else if (hitCtl) rdData = ctlView;
  end

  assign rdEn = !bus.we && (hitCnt || hitLim || hitCtl);
  assign DBUS = rdEn ? rdData : 32'hzzzz_zzzz;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prescaler <= '0;
      tCnt      <= 32'd0;
      tLim      <= 32'd0;
      ready     <= 1'b0;
      overrun   <= 1'b0;
      intEn     <= 1'b0;
      TIRQ      <= 1'b0;
    end else begin
      if (wrLim) begin
        tLim      <= DBUS;
        tCnt      <= 32'd0;
        prescaler <= '0;
      end else begin
        prescaler <= tick ? '0 : prescaler + PS_ONE;
        if (wrCnt)     tCnt <= DBUS;
        else if (tick) tCnt <= wrap ? 32'd0 : tCnt + 32'd1;
      end

      if (wrCtl) intEn <= DBUS[8];
      // Hardware set beats a same-edge software clear so no wrap is lost.
      ready   <= wrap | (wrCtl ? (DBUS[0] & ready) : ready);
      overrun <= (wrap & ready) | (wrCtl ? (DBUS[2] & overrun) : overrun);
      TIRQ    <= ready & intEn & IE;
    end
  end

endmodule

// File: tb/tb_timer_device.sv
// tb/tb_timer_device.sv - directed bench for timer_device with TICK_DIV=4
module tb_timer_device;
  localparam logic [31:0] A_TCNT = 32'hF0000020;
  localparam logic [31:0] A_TLIM = 32'hF0000024;
  localparam logic [31:0] A_TCTL = 32'hF0000120;
  localparam logic [31:0] A_NONE = 32'hF0000028;

  logic        clk;
  logic        rst;
  logic        ie;
  logic        tirq;
  logic [31:0] tbData;
  logic        tbDrive;
  tri   [31:0] dbus;

  int total;
  int bad;

  timer_device_if busIf ();

  pullup (dbus);
  assign dbus = tbDrive ? tbData : 32'hzzzz_zzzz;

  timer_device #(.TICK_DIV(4)) dut (
    .clk  (clk),
    .rst  (rst),
    .bus  (busIf),
    .DBUS (dbus),
    .IE   (ie),
    .TIRQ (tirq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic busWrite(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    busIf.ABUS = a;
    busIf.we   = 1'b1;
    tbData     = d;
    tbDrive    = 1'b1;
    @(posedge clk);
    #1;
    busIf.we   = 1'b0;
    tbDrive    = 1'b0;
    busIf.ABUS = 32'h0;
  endtask

  task automatic readNow(input logic [31:0] a, output logic [31:0] d);
    busIf.ABUS = a;
    busIf.we   = 1'b0;
    #1;
    d = dbus;
    busIf.ABUS = 32'h0;
  endtask

  task automatic test_reset;
    logic [31:0] v;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    readNow(A_TCNT, v);
    total++; if (v !== 32'd0) begin bad++; $display("FAIL reset_tcnt got=%h want=%h", v, 32'd0); end
    readNow(A_TLIM, v);
    total++; if (v !== 32'd0) begin bad++; $display("FAIL reset_tlim got=%h want=%h", v, 32'd0); end
    readNow(A_TCTL, v);
    total++; if (v !== 32'd0) begin bad++; $display("FAIL reset_tctl got=%h want=%h", v, 32'd0); end
    @(negedge clk);
    total++; if (tirq !== 1'b0) begin bad++; $display("FAIL reset_tirq got=%b want=0", tirq); end
    readNow(A_NONE, v);
    total++; if (v !== 32'hFFFFFFFF) begin bad++; $display("FAIL reset_bus_released got=%h want=%h", v, 32'hFFFFFFFF); end
    rst = 1'b1;
  endtask

  task automatic test_free_run;
    logic [31:0] v;
    repeat (40) @(posedge clk);
    @(negedge clk);
    readNow(A_TCNT, v);
    total++; if (v !== 32'd10) begin bad++; $display("FAIL free_run_count got=%0d want=10", v); end
    busWrite(A_TCNT, 32'hFFFFFFFF);
    repeat (3) @(posedge clk);
    @(negedge clk);
    readNow(A_TCNT, v);
    total++; if (v !== 32'd0) begin bad++; $display("FAIL free_run_rollover got=%h want=%h", v, 32'd0); end
    readNow(A_TCTL, v);
    total++; if (v !== 32'd0) begin bad++; $display("FAIL free_run_no_ready got=%h want=%h", v, 32'd0); end
  endtask

  task automatic test_limit;
    logic [31:0] v;
    ie = 1'b1;
    busWrite(A_TLIM, 32'd3);
    busWrite(A_TCTL, 32'h100);
    repeat (11) @(posedge clk);
    @(negedge clk);
    readNow(A_TCNT, v);
    total++; if (v !== 32'd0) begin bad++; $display("FAIL limit_wrap_tcnt got=%h want=%h", v, 32'd0); end
    readNow(A_TCTL, v);
    total++; if (v !== 32'h101) begin bad++; $display("FAIL limit_ready got=%h want=%h", v, 32'h101); end
    total++; if (tirq !== 1'b0) begin bad++; $display("FAIL limit_tirq_latency got=%b want=0", tirq); end
    @(negedge clk);
    total++; if (tirq !== 1'b1) begin bad++; $display("FAIL limit_tirq_set got=%b want=1", tirq); end
    busWrite(A_TCTL, 32'h100);
    @(negedge clk);
    readNow(A_TCTL, v);
    total++; if (v !== 32'h100) begin bad++; $display("FAIL limit_ready_clear got=%h want=%h", v, 32'h100); end
    total++; if (tirq !== 1'b1) begin bad++; $display("FAIL limit_tirq_hold got=%b want=1", tirq); end
    @(negedge clk);
    total++; if (tirq !== 1'b0) begin bad++; $display("FAIL limit_tirq_clear got=%b want=0", tirq); end
  endtask

  task automatic test_overrun;
    logic [31:0] v;
    busWrite(A_TLIM, 32'd2);
    repeat (8) @(posedge clk);
    @(negedge clk);
    readNow(A_TCTL, v);
    total++; if (v !== 32'h101) begin bad++; $display("FAIL overrun_first_wrap got=%h want=%h", v, 32'h101); end
    repeat (8) @(posedge clk);
    @(negedge clk);
    readNow(A_TCTL, v);
    total++; if (v !== 32'h105) begin bad++; $display("FAIL overrun_set got=%h want=%h", v, 32'h105); end
    busWrite(A_TCTL, 32'h104);
    @(negedge clk);
    readNow(A_TCTL, v);
    total++; if (v !== 32'h104) begin bad++; $display("FAIL overrun_keep got=%h want=%h", v, 32'h104); end
    busWrite(A_TCTL, 32'h100);
    @(negedge clk);
    readNow(A_TCTL, v);
    total++; if (v !== 32'h100) begin bad++; $display("FAIL overrun_clear got=%h want=%h", v, 32'h100); end
  endtask

  task automatic test_collisions;
    logic [31:0] v;
    busWrite(A_TLIM, 32'd2);
    repeat (7) @(posedge clk);
    busWrite(A_TCTL, 32'h100);
    @(negedge clk);
    readNow(A_TCTL, v);
    total++; if (v !== 32'h101) begin bad++; $display("FAIL collide_ready_wins got=%h want=%h", v, 32'h101); end
    repeat (3) @(posedge clk);
    busWrite(A_TCNT, 32'd7);
    @(negedge clk);
    readNow(A_TCNT, v);
    total++; if (v !== 32'd7) begin bad++; $display("FAIL collide_tcnt_write got=%0d want=7", v); end
    repeat (4) @(posedge clk);
    @(negedge clk);
    readNow(A_TCNT, v);
    total++; if (v !== 32'd8) begin bad++; $display("FAIL prescaler_undisturbed got=%0d want=8", v); end
  endtask

  task automatic test_gating;
    @(negedge clk);
    ie = 1'b0;
    @(posedge clk);
    @(negedge clk);
    total++; if (tirq !== 1'b0) begin bad++; $display("FAIL gate_ie_off got=%b want=0", tirq); end
    ie = 1'b1;
    #1;
    total++; if (tirq !== 1'b0) begin bad++; $display("FAIL gate_ie_registered got=%b want=0", tirq); end
    @(posedge clk);
    @(negedge clk);
    total++; if (tirq !== 1'b1) begin bad++; $display("FAIL gate_ie_on got=%b want=1", tirq); end
  endtask

  task automatic test_async_reset;
    logic [31:0] v;
    @(negedge clk);
    #1;
    rst = 1'b0;
    #1;
    total++; if (tirq !== 1'b0) begin bad++; $display("FAIL areset_tirq got=%b want=0", tirq); end
    readNow(A_TCNT, v);
    total++; if (v !== 32'd0) begin bad++; $display("FAIL areset_tcnt got=%h want=%h", v, 32'd0); end
    readNow(A_TLIM, v);
    total++; if (v !== 32'd0) begin bad++; $display("FAIL areset_tlim got=%h want=%h", v, 32'd0); end
    @(negedge clk);
    readNow(A_TCTL, v);
    total++; if (v !== 32'd0) begin bad++; $display("FAIL areset_tctl got=%h want=%h", v, 32'd0); end
    rst = 1'b1;
    repeat (4) @(posedge clk);
    @(negedge clk);
    readNow(A_TCNT, v);
    total++; if (v !== 32'd1) begin bad++; $display("FAIL areset_resume got=%0d want=1", v); end
    readNow(A_NONE, v);
    total++; if (v !== 32'hFFFFFFFF) begin bad++; $display("FAIL unmatched_released got=%h want=%h", v, 32'hFFFFFFFF); end
  endtask

  initial begin
    total      = 0;
    bad        = 0;
    rst        = 1'b0;
    ie         = 1'b0;
    tbData     = 32'd0;
    tbDrive    = 1'b0;
    busIf.ABUS = 32'h0;
    busIf.we   = 1'b0;
    test_reset();
    test_free_run();
    test_limit();
    test_overrun();
    test_collisions();
    test_gating();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
